// File: rtl/coin_dispenser.sv
// Change dispenser: pays out an amount in nickel units using dimes first, then nickels,
// waiting for a hopper acknowledge after every coin and giving up after ACK_TIMEOUT cycles.
module coin_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       dime_empty,
  input  logic       nickel_empty,
  input  logic       coin_ack,
  output logic [1:0] coin,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       fault,
  output logic [3:0] owed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_rem;
  logic [7:0] r_cnt;
  logic       r_is_dime;
  logic [1:0] r_coin;
  logic       r_busy;
  logic       r_done;
  logic       r_short;
  logic       r_fault;

  logic       w_timeout;
  logic [3:0] w_step;

  function automatic logic [3:0] sub_sat(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? (a - b) : 4'd0;
  endfunction

  assign w_timeout = (r_cnt == LP_TO_LAST);
  assign w_step    = r_is_dime ? 4'd2 : 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rem     <= 4'd0;
      r_cnt     <= 8'd0;
      r_is_dime <= 1'b0;
      r_coin    <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_short   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_coin <= 2'b00;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem   <= amount;
            r_short <= 1'b0;
            r_fault <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SELECT;
          end
        end
        // Hopper-empty flags are only looked at here, so a coin in flight is never redirected.
        S_SELECT: begin
          if (r_rem == 4'd0) begin
            r_short <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_rem >= 4'd2 && !dime_empty) begin
            r_is_dime <= 1'b1;
            r_coin    <= 2'b10;
            r_state   <= S_ISSUE;
          end else if (!nickel_empty) begin
            r_is_dime <= 1'b0;
            r_coin    <= 2'b01;
            r_state   <= S_ISSUE;
          end else begin
            r_short <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= 8'd0;
          r_state <= S_WAIT_ACK;
        end
        // An acknowledge arriving on the final timeout cycle still counts as delivered.
        S_WAIT_ACK: begin
          if (coin_ack) begin
            r_rem   <= sub_sat(r_rem, w_step);
            r_state <= S_SELECT;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_short <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign coin  = r_coin;
  assign busy  = r_busy;
  assign done  = r_done;
  assign short = r_short;
  assign fault = r_fault;
  assign owed  = r_rem;

endmodule

// File: tb/tb_coin_dispenser.sv
// Scoreboard bench for coin_dispenser: a payout model predicts coins and final status,
// a hopper responder acknowledges coins with planned delays, and a monitor checks the DUT.
module tb_coin_dispenser;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] amount;
  logic       dime_empty;
  logic       nickel_empty;
  logic       coin_ack;
  logic [1:0] coin;
  logic       busy;
  logic       done;
  logic       short;
  logic       fault;
  logic [3:0] owed;

  coin_dispenser #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .dime_empty(dime_empty), .nickel_empty(nickel_empty), .coin_ack(coin_ack),
    .coin(coin), .busy(busy), .done(done), .short(short), .fault(fault), .owed(owed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] exp_coin_q[$];
  logic [5:0] exp_res_q[$];
  int         dq[$];

  bit         mon_en = 1'b0;
  bit         first_pending = 1'b0;
  int         start_cyc = 0;
  int         last_coin_cyc = 0;
  logic [1:0] prev_coin = 2'b00;
  logic       prev_done = 1'b0;
  int         exp_owed = 0;
  bit         exp_short = 1'b0;
  bit         exp_fault = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Payout rules: largest coin that fits and is stocked; an ack counts if it arrives
  // 1..T cycles after the coin strobe, otherwise the payout faults with the balance unchanged.
  task automatic model(input int amt, input bit de, input bit ne);
    int rem;
    int i;
    int val;
    int d;
    bit sh;
    bit fl;
    rem = amt; i = 0; sh = 0; fl = 0;
    for (int k = 0; k < 40; k++) begin
      if (rem == 0) begin sh = 0; break; end
      if (rem >= 2 && !de)      val = 2;
      else if (rem >= 1 && !ne) val = 1;
      else begin sh = 1; break; end
      exp_coin_q.push_back(val == 2 ? 2'b10 : 2'b01);
      d = (i < dq.size()) ? dq[i] : 1;
      i++;
      if (d >= 1 && d <= T) rem = rem - val;
      else begin fl = 1; sh = 1; break; end
    end
    exp_res_q.push_back({sh, fl, 4'(rem)});
    exp_owed = rem; exp_short = sh; exp_fault = fl;
  endtask

  always @(negedge clk) begin
    logic [5:0] r;
    if (mon_en && rst === 1'b1) begin
      if (coin !== 2'b00) begin
        check("coin_not_11", {31'd0, coin == 2'b11}, 0);
        check("coin_one_cycle", {30'd0, prev_coin}, 0);
        if (exp_coin_q.size() == 0) check("unexpected_coin", {30'd0, coin}, 0);
        else check("coin_value", {30'd0, coin}, {30'd0, exp_coin_q.pop_front()});
        if (first_pending) begin
          check("first_latency", cyc - start_cyc, 2);
          first_pending = 1'b0;
        end
        last_coin_cyc = cyc;
      end
      if (done === 1'b1) begin
        check("done_one_cycle", {31'd0, prev_done}, 0);
        check("busy_in_done", {31'd0, busy}, 1);
        if (first_pending) begin
          check("first_latency", cyc - start_cyc, 2);
          first_pending = 1'b0;
        end
        if (exp_res_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          r = exp_res_q.pop_front();
          check("short", {31'd0, short}, {31'd0, r[5]});
          check("fault", {31'd0, fault}, {31'd0, r[4]});
          check("owed", {28'd0, owed}, {28'd0, r[3:0]});
          if (r[4]) check("timeout_gap", cyc - last_coin_cyc, T + 1);
          check("coins_consumed", exp_coin_q.size(), 0);
        end
      end
    end
    prev_coin = coin;
    prev_done = done;
  end

  // Entered and left at posedge+1 with the DUT idle; dq holds the planned ack delays.
  task automatic run_txn(input int amt, input bit de, input bit ne);
    int  cnt;
    bit  got_done;
    model(amt, de, ne);
    amount = 4'(amt); dime_empty = de; nickel_empty = ne; coin_ack = 1'b0;
    start = 1'b1; start_cyc = cyc; first_pending = 1'b1;
    cnt = -1; got_done = 1'b0;
    for (int k = 0; k < 400 && !got_done; k++) begin
      @(posedge clk); #1;
      start  = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      amount = 4'($urandom);
      if (cnt >= 0) cnt--;
      if (coin !== 2'b00) cnt = (dq.size() > 0) ? dq.pop_front() : 1;
      coin_ack = (cnt == 0);
      if (cnt > 0) begin
        dime_empty = 1'($urandom); nickel_empty = 1'($urandom);
      end else begin
        dime_empty = de; nickel_empty = ne;
      end
      if (done === 1'b1) begin
        got_done = 1'b1; start = 1'b0; coin_ack = 1'b0;
        dime_empty = de; nickel_empty = ne;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      check("done_within_budget", 0, 1);
      exp_coin_q.delete(); exp_res_q.delete(); first_pending = 1'b0;
    end
    @(posedge clk); #1;
    check("idle_busy", {31'd0, busy}, 0);
    repeat ($urandom_range(0, 3)) begin
      coin_ack = 1'($urandom);
      @(posedge clk); #1;
    end
    coin_ack = 1'b0;
    check("owed_hold", {28'd0, owed}, exp_owed);
    check("short_hold", {31'd0, short}, {31'd0, exp_short});
    check("fault_hold", {31'd0, fault}, {31'd0, exp_fault});
    dq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; amount = 4'd0; dime_empty = 1'b0;
    nickel_empty = 1'b0; coin_ack = 1'b0;
    #2;
    check("rst_coin", {30'd0, coin}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_short", {31'd0, short}, 0);
    check("rst_fault", {31'd0, fault}, 0);
    check("rst_owed", {28'd0, owed}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b1;

    dq = {2, 2};            run_txn(3, 0, 0);
                            run_txn(0, 0, 0);
    dq = {1, 2, 3, 1};      run_txn(4, 1, 0);
                            run_txn(2, 1, 1);
    dq = {255};             run_txn(3, 0, 0);
    dq = {T, T};            run_txn(4, 0, 0);
    dq = {0};               run_txn(1, 0, 0);
    dq = {T + 1};           run_txn(2, 1, 0);
                            run_txn(15, 0, 1);
                            run_txn(15, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int amt;
      bit de;
      bit ne;
      amt = $urandom_range(0, 15);
      de  = ($urandom_range(0, 4) == 0);
      ne  = ($urandom_range(0, 4) == 0);
      for (int j = 0; j < 10; j++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5)      dq.push_back($urandom_range(1, 3));
        else if (r == 6) dq.push_back(T);
        else if (r == 7) dq.push_back(T + 1);
        else if (r == 8) dq.push_back(0);
        else             dq.push_back(1);
      end
      run_txn(amt, de, ne);
    end

    // Asynchronous reset in the middle of a payout.
    mon_en = 1'b0;
    amount = 4'd5; dime_empty = 1'b0; nickel_empty = 1'b0; coin_ack = 1'b0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midpay_busy", {31'd0, busy}, 1);
    check("midpay_owed", {28'd0, owed}, 5);
    #2; rst = 1'b0; #1;
    check("arst_coin", {30'd0, coin}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_owed", {28'd0, owed}, 0);
    check("arst_done", {31'd0, done}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_coin_q.delete(); exp_res_q.delete(); first_pending = 1'b0;
    mon_en = 1'b1;
    dq = {2, 1};            run_txn(3, 0, 0);

    check("queues_drained", exp_coin_q.size() + exp_res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
